// File: rtl/boot_pkg.sv
// Shared types and widths for the boot loader: FSM state encoding and
// stream/word geometry.
package boot_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BCNT_W = 2;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    CSUM,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Little-endian assembler: collects 4 bytes into a 32-bit word, first byte
// in bits [7:0]. word/word_valid are combinational on the 4th strobe.
module byte_packer
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              strobe,
  input  logic              clear,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [BCNT_W-1:0]        cnt_q, cnt_d;
  logic [WORD_W-BYTE_W-1:0] low_q, low_d;

  // Lower three bytes shift in from the top so byte 0 lands at [7:0].
  assign word       = {in_byte, low_q};
  assign word_valid = strobe && (cnt_q == '1);

  always_comb begin
    cnt_d = cnt_q;
    low_d = low_q;
    if (clear) begin
      cnt_d = '0;
      low_d = '0;
    end else if (strobe) begin
      cnt_d = cnt_q + BCNT_W'(1);
      low_d = {in_byte, low_q[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      low_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      low_q <= low_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction
// memory and holds the core in reset until the image verifies.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned ADDR_W     = $clog2(IMEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [WORD_W-1:0]   csum_q, csum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;

  logic                accept;
  logic [WORD_W-1:0]   word;
  logic                word_valid;

  assign in_ready = (state_q == HDR) || (state_q == LOAD) || (state_q == CSUM);
  assign accept   = in_valid && in_ready;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .in_byte    (in_data),
    .strobe     (accept),
    .clear      (!in_ready),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (word_valid) begin
      unique case (state_q)
        HDR: begin
          if (word > WORD_W'(IMEM_WORDS)) begin
            state_d = ERR;
          end else if (word == '0) begin
            state_d = CSUM;
          end else begin
            state_d = LOAD;
            n_d     = word[ADDR_W:0];
            idx_d   = '0;
          end
        end
        LOAD: begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          wdata_d = word;
          csum_d  = csum_q ^ word;
          idx_d   = idx_q + (ADDR_W+1)'(1);
          if (idx_d == n_q) state_d = CSUM;
        end
        CSUM: state_d = (word == csum_q) ? DONE : ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HDR;
      idx_q   <= '0;
      n_q     <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);
  assign core_rst   = (state_q != DONE);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table of whole-image loads plus hand
// sequences for oversize header, post-DONE traffic and mid-load reset.
module tb_boot_loader;

  localparam int unsigned IMEM_WORDS = 8;
  localparam int unsigned ADDR_W     = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa [$];
  logic [31:0] wd [$];

  typedef struct {
    logic [31:0] n;
    logic [31:0] w [8];
    logic [31:0] csum;
    int unsigned gmax;
    logic        exp_done;
  } vec_t;

  vec_t tbl [6];

  boot_loader #(.IMEM_WORDS(IMEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(32'(imem_addr));
      wd.push_back(imem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("handshake_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned gmax);
    for (int b = 0; b < 4; b++)
      send_byte(w[8*b +: 8], (gmax == 0) ? 0 : $urandom_range(0, gmax));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wa.delete();
    wd.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
    chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    chk({tag, "_core_rst"},   32'(core_rst),   32'd1);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_err"},        32'(err),        32'd0);
  endtask

  task automatic check_writes(input string tag, input vec_t v);
    chk({tag, "_wcount"}, 32'(wa.size()), v.n);
    for (int k = 0; k < wa.size() && k < int'(v.n); k++) begin
      chk($sformatf("%s_waddr%0d", tag, k), wa[k], 32'(k));
      chk($sformatf("%s_wdata%0d", tag, k), wd[k], v.w[k]);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    do_reset();
    send_word(v.n, v.gmax);
    for (int k = 0; k < int'(v.n); k++) send_word(v.w[k], v.gmax);
    send_word(v.csum, v.gmax);
    chk({tag, "_done"},     32'(done),     32'(v.exp_done));
    chk({tag, "_err"},      32'(err),      32'(!v.exp_done));
    chk({tag, "_core_rst"}, 32'(core_rst), 32'(!v.exp_done));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_writes(tag, v);
  endtask

  initial begin
    int nw;
    tbl[0] = '{32'd3, '{32'h00000013, 32'h00100093, 32'hFFDFF06F, 0, 0, 0, 0, 0},
               32'hFFCFF0EF, 0, 1'b1};
    tbl[1] = '{32'd3, '{32'h00000013, 32'h00100093, 32'hFFDFF06F, 0, 0, 0, 0, 0},
               32'h00000000, 0, 1'b0};
    tbl[2] = '{32'd0, '{0, 0, 0, 0, 0, 0, 0, 0}, 32'h00000000, 0, 1'b1};
    tbl[3] = '{32'd3, '{32'h00000013, 32'h00100093, 32'hFFDFF06F, 0, 0, 0, 0, 0},
               32'hFFCFF0EF, 3, 1'b1};
    tbl[4] = '{32'd8, '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                        32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777},
               32'h00000000, 1, 1'b1};
    tbl[5] = '{32'd1, '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0}, 32'hDEADBEEE, 0, 1'b0};

    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    // Traffic after DONE must be ignored.
    run_vec(10, tbl[0]);
    nw       = wa.size();
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_done_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("post_done_wcount", 32'(wa.size()), 32'(nw));
    chk("post_done_done",   32'(done),      32'd1);

    // Oversize header: N = IMEM_WORDS + 1.
    do_reset();
    send_byte(8'h09, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("big_err_early", 32'(err), 32'd0);
    send_byte(8'h00, 0);
    chk("big_err",      32'(err),       32'd1);
    chk("big_done",     32'(done),      32'd0);
    chk("big_core_rst", 32'(core_rst),  32'd1);
    chk("big_in_ready", 32'(in_ready),  32'd0);
    repeat (3) @(negedge clk);
    chk("big_wcount",   32'(wa.size()), 32'd0);

    // Reset after the 6th payload byte, then full reload.
    do_reset();
    send_word(32'd3, 0);
    send_word(32'h00000013, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    chk("mid_wcount_pre", 32'(wa.size()), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid");
    do_reset();
    send_word(32'd3, 0);
    for (int k = 0; k < 3; k++) send_word(tbl[0].w[k], 0);
    send_word(32'hFFCFF0EF, 0);
    chk("mid_done",     32'(done),     32'd1);
    chk("mid_core_rst", 32'(core_rst), 32'd0);
    check_writes("mid", tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
